// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the PS/2 lines,
// deframes 11-bit frames and strobes out good bytes, parity errors and frame errors.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_2,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] check_code,
  output logic       code_new_updated,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             clk_f_q, clk_f_d, clk_f_last_q;
  logic             fe_s;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       code_q, code_d;
  logic             new_q, new_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;

  assign fe_s = clk_f_last_q & ~clk_f_q;

  // clk_f only moves after FILTER_LEN consecutive samples that disagree with it
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    clk_f_d   = clk_f_q;
    if (clk_s2_q == clk_f_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FLT_LAST) begin
      flt_cnt_d = '0;
      clk_f_d   = clk_s2_q;
    end else begin
      flt_cnt_d = flt_cnt_q + FLT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wd_d      = wd_q;
    code_d    = code_q;
    new_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (fe_s && !data_s2_q) begin
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (fe_s) begin
          shift_d = {data_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (fe_s) begin
          parity_d = data_s2_q;
          state_d  = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (fe_s) begin
          state_d = IDLE;
          if (!data_s2_q) begin
            ferr_d = 1'b1;
          end else if (^{shift_q, parity_q} == 1'b0) begin
            perr_d = 1'b1;
          end else begin
            code_d = shift_q;
            new_d  = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // wd_q holds the number of cycles elapsed since the last fe
    if (state_q != IDLE) begin
      if (fe_s) begin
        wd_d = WD_ONE;
      end else if (wd_q >= WD_LAST) begin
        wd_d    = '0;
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else begin
        wd_d = wd_q + WD_ONE;
      end
    end else begin
      wd_d = (state_d == IDLE) ? '0 : WD_ONE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      flt_cnt_q    <= '0;
      clk_f_q      <= 1'b1;
      clk_f_last_q <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      wd_q         <= '0;
      code_q       <= 8'h00;
      new_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      data_s1_q    <= ps2_data;
      data_s2_q    <= data_s1_q;
      flt_cnt_q    <= flt_cnt_d;
      clk_f_q      <= clk_f_d;
      clk_f_last_q <= clk_f_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      wd_q         <= wd_d;
      code_q       <= code_d;
      new_q        <= new_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      busy_q       <= busy_d;
    end
  end

  assign check_code       = code_q;
  assign code_new_updated = new_q;
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;
  assign busy             = busy_q;

endmodule
